instruction_memory_responder: RTL

INSTRUCTION_MEMORY_RESPONDER -- requirements
Module: instruction_memory_responder

---
 rtl/instruction_package.sv | 14 +
 rtl/instruction_memory_responder_if.sv | 28 ++
 rtl/instruction_ram.sv | 28 ++
 rtl/instruction_memory_responder.sv | 88 ++++++++
 4 files changed

// File: rtl/instruction_package.sv
// rtl/instruction_package.sv - regex_cpu instruction encoding shared by the fetch path
package instruction_package;

  localparam int INSTRUCTION_WIDTH      = 4;
  localparam int INSTRUCTION_DATA_WIDTH = 16;

  localparam logic [INSTRUCTION_WIDTH-1:0] END_WITHOUT_ACCEPTING = 4'd2;

  typedef struct packed {
    logic [INSTRUCTION_WIDTH-1:0]      opcode;
    logic [INSTRUCTION_DATA_WIDTH-1:0] data;
  } instruction_t;

endpackage

// File: rtl/instruction_memory_responder_if.sv
// rtl/instruction_memory_responder_if.sv - fetch ports and program-load bus of the instruction memory
interface instruction_memory_responder_if #(
  parameter int N_PORTS           = 4,
  parameter int MEMORY_WIDTH      = 20,
  parameter int MEMORY_ADDR_WIDTH = 11
);

  logic [N_PORTS-1:0]                   memory_valid;
  logic [N_PORTS*MEMORY_ADDR_WIDTH-1:0] memory_addr;
  logic [N_PORTS-1:0]                   memory_ready;
  logic [MEMORY_WIDTH-1:0]              memory_data;
  logic                                 load_valid;
  logic [MEMORY_ADDR_WIDTH-1:0]         load_addr;
  logic [MEMORY_WIDTH-1:0]              load_data;
  logic                                 load_ready;
  logic                                 busy;

  modport master (
    output memory_valid, memory_addr, load_valid, load_addr, load_data,
    input  memory_ready, memory_data, load_ready, busy
  );

  modport slave (
    input  memory_valid, memory_addr, load_valid, load_addr, load_data,
    output memory_ready, memory_data, load_ready, busy
  );

endinterface

// File: rtl/instruction_ram.sv
// rtl/instruction_ram.sv - single-port synchronous RAM, one write or one registered read per cycle
module instruction_ram #(
  parameter int WIDTH      = 20,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [WIDTH-1:0] rdata_q;

  // The read register only loads on a read, so writes leave it untouched.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end else if (re) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/instruction_memory_responder.sv
// rtl/instruction_memory_responder.sv - round-robin fetch arbiter with load priority in front of instruction_ram
module instruction_memory_responder
  import instruction_package::*;
#(
  parameter int N_PORTS           = 4,
  parameter int MEMORY_WIDTH      = 20,
  parameter int MEMORY_ADDR_WIDTH = 11
) (
  input  logic                            clk,
  input  logic                            rst,
  instruction_memory_responder_if.slave   bus
);

  localparam int PTR_W = $clog2(N_PORTS);
  localparam instruction_t RESET_INSTR = '{opcode: END_WITHOUT_ACCEPTING, data: '0};
  localparam logic [MEMORY_WIDTH-1:0] RESET_WORD = MEMORY_WIDTH'(RESET_INSTR);

  logic [PTR_W-1:0]             ptr_q, ptr_d;
  logic [PTR_W-1:0]             scan_idx;
  logic [PTR_W-1:0]             grant_idx;
  logic                         grant_any;
  logic [N_PORTS-1:0]           grant;
  logic                         rd_pend_q, rd_pend_d;
  logic [MEMORY_WIDTH-1:0]      hold_q, hold_d;
  logic [MEMORY_WIDTH-1:0]      ram_rdata;
  logic [MEMORY_ADDR_WIDTH-1:0] ram_addr;
  logic                         ram_we;

  // Scan from the pointer; N_PORTS is a power of two so the index wraps naturally.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    grant     = '0;
    if (!rst && !bus.load_valid) begin
      for (int i = 0; i < N_PORTS; i++) begin
        scan_idx = ptr_q + PTR_W'(i);
        if (!grant_any && bus.memory_valid[scan_idx]) begin
          grant_any = 1'b1;
          grant_idx = scan_idx;
        end
      end
    end
    if (grant_any) begin
      grant[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    ptr_d     = grant_any ? grant_idx + PTR_W'(1) : ptr_q;
    ram_we    = bus.load_valid & ~rst;
    ram_addr  = bus.load_valid ? bus.load_addr
                               : bus.memory_addr[grant_idx*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];
    rd_pend_d = grant_any;
    hold_d    = rd_pend_q ? ram_rdata : hold_q;
  end

  // hold_q carries the last returned word so a reset can override the RAM's own read register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      rd_pend_q <= 1'b0;
      hold_q    <= RESET_WORD;
    end else begin
      ptr_q     <= ptr_d;
      rd_pend_q <= rd_pend_d;
      hold_q    <= hold_d;
    end
  end

  instruction_ram #(
    .WIDTH      (MEMORY_WIDTH),
    .ADDR_WIDTH (MEMORY_ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (grant_any),
    .addr  (ram_addr),
    .wdata (bus.load_data),
    .rdata (ram_rdata)
  );

  assign bus.memory_ready = grant;
  assign bus.memory_data  = rd_pend_q ? ram_rdata : hold_q;
  assign bus.load_ready   = ram_we;
  assign bus.busy         = (|bus.memory_valid) | bus.load_valid;

endmodule
